// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, per-round shift amounts,
// schedule FSM states and the 28-bit half rotation helper.
package des_pkg;

    typedef enum logic [1:0] {IDLE, GEN, DONE} ks_state_t;
    typedef logic [47:0] subkey_t;

    // Tables use DES numbering: bit 1 is the MSB of the source word.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] LSHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Rotation toward the LSB, undoing the encrypt-direction left shift.
    function automatic logic [27:0] ror28(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        r = (n == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
        return r;
    endfunction

    // Returns {C0, D0}; parity bits never appear in the table.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = key[64-PC1_TAB[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression of the 56-bit {C,D} register pair into a 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output subkey_t     subkey
);

    for (genvar gi = 0; gi < 48; gi++) begin : g_perm
        assign subkey[47-gi] = cd[56-PC2_TAB[gi]];
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// DES decrypt key scheduler: emits K16..K1 one per handshake by rotating C/D
// right from C16=C0, so no subkey storage is required.
module des_dec_key_sched
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output subkey_t     subkey,
    output logic [3:0]  subkey_idx,
    output logic        subkey_valid,
    output logic        busy,
    output logic        done
);

    ks_state_t   state_reg, state_next;
    logic [27:0] c_reg, c_next;
    logic [27:0] d_reg, d_next;
    logic [3:0]  idx_reg, idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        c_next       = c_reg;
        d_next       = d_reg;
        idx_next     = idx_reg;
        subkey_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    {c_next, d_next} = pc1(key_in);
                    idx_next         = 4'(NUM_ROUNDS - 1);
                    state_next       = GEN;
                end
            end
            GEN: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
                if (subkey_ready) begin
                    // Registers stay at C1/D1 after the last subkey is taken.
                    if (idx_reg == 4'd0) begin
                        state_next = DONE;
                    end else begin
                        c_next   = ror28(c_reg, LSHIFT[idx_reg]);
                        d_next   = ror28(d_reg, LSHIFT[idx_reg]);
                        idx_next = idx_reg - 4'd1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign subkey_idx = idx_reg;

    des_pc2 u_pc2 (
        .cd     ({c_reg, d_reg}),
        .subkey (subkey)
    );

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Directed bench for the DES decrypt key scheduler against the textbook
// 133457799BBCDFF1 key schedule, with backpressure, parity, busy and reset cases.
module tb_des_dec_key_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_idx;
    logic        subkey_valid;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // kref[i] is K(i+1) of the classic worked example.
    logic [47:0] kref [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des_dec_key_sched #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_idx   (subkey_idx),
        .subkey_valid (subkey_valid),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // mode 0: ready high; 1: random ready with 20-cycle stall at idx 8;
    // 2: start re-asserted with all-ones key at idx 10; 3: reset at idx 5.
    task automatic run_stream(input string name, input logic [63:0] key,
                              input bit zero_exp, input int mode);
        int          exp_idx = 15;
        int          k = 0;
        int          stall_left = 0;
        bit          stall_used = 1'b0;
        bit          prev_hold = 1'b0;
        bit          fin = 1'b0;
        logic [47:0] prev_sk = '0;
        logic [3:0]  prev_ix = '0;
        @(negedge clk);
        key_in       = key;
        start        = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = 64'hA5A5_5A5A_0F0F_F0F0;
        while (!fin && k < 300) begin
            if (prev_hold) begin
                chk({name, " hold subkey"}, 64'(subkey), 64'(prev_sk));
                chk({name, " hold idx"}, 64'(subkey_idx), 64'(prev_ix));
            end
            prev_hold = 1'b0;
            if (subkey_valid) begin
                if (exp_idx < 0) begin
                    chk({name, " extra subkey"}, 64'(1), 64'(0));
                    fin = 1'b1;
                end else begin
                    chk({name, " idx"}, 64'(subkey_idx), 64'(exp_idx));
                    chk({name, " subkey"}, 64'(subkey), zero_exp ? 64'(0) : 64'(kref[exp_idx]));
                    if (mode == 3 && exp_idx == 5) begin
                        rst = 1'b1;
                        @(negedge clk);
                        chk({name, " after rst valid/busy/done"},
                            64'({subkey_valid, busy, done}), 64'(0));
                        chk({name, " after rst idx/subkey"}, 64'({subkey_idx, subkey}), 64'(0));
                        rst = 1'b0;
                        return;
                    end
                    if (mode == 1) begin
                        if (exp_idx == 8 && !stall_used) begin
                            stall_left = 20;
                            stall_used = 1'b1;
                        end
                        if (stall_left > 0) begin
                            subkey_ready = 1'b0;
                            stall_left--;
                        end else begin
                            subkey_ready = 1'($urandom_range(0, 1));
                        end
                    end
                    start  = (mode == 2 && exp_idx == 10);
                    key_in = start ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hA5A5_5A5A_0F0F_F0F0;
                    if (subkey_ready) begin
                        exp_idx--;
                    end else begin
                        prev_hold = 1'b1;
                        prev_sk   = subkey;
                        prev_ix   = subkey_idx;
                    end
                end
            end else if (done) begin
                start = 1'b0;
                chk({name, " all subkeys before done"}, 64'(exp_idx + 1), 64'(0));
                if (mode != 1) chk({name, " done cycle"}, 64'(k), 64'(16));
                @(negedge clk);
                chk({name, " single done, idle"}, 64'({done, busy, subkey_valid}), 64'(0));
                fin = 1'b1;
            end else begin
                chk({name, " lost schedule busy/valid/done"},
                    64'({busy, subkey_valid, done}), 64'(3'b110));
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                k++;
            end
        end
        if (!fin) chk({name, " timeout"}, 64'(0), 64'(1));
        start        = 1'b0;
        subkey_ready = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        subkey_ready = 1'b0;
        key_in       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid/busy/done", 64'({subkey_valid, busy, done}), 64'(0));
        chk("reset subkey", 64'(subkey), 64'(0));
        chk("reset idx", 64'(subkey_idx), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle no start", 64'({subkey_valid, busy, done, subkey_idx, subkey}), 64'(0));
        end

        run_stream("known", 64'h1334_5779_9BBC_DFF1, 1'b0, 0);
        run_stream("backpressure", 64'h1334_5779_9BBC_DFF1, 1'b0, 1);
        run_stream("parity_a", 64'h1234_5678_9ABC_DEF0, 1'b0, 0);
        run_stream("parity_b", 64'h1335_5779_9BBD_DFF1, 1'b0, 0);
        run_stream("zero_key", 64'h0, 1'b1, 0);
        run_stream("busy_start", 64'h1334_5779_9BBC_DFF1, 1'b0, 2);
        run_stream("mid_reset", 64'h1334_5779_9BBC_DFF1, 1'b0, 3);
        run_stream("after_reset", 64'h1334_5779_9BBC_DFF1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
